// File: rtl/vga_timing_gen_if.sv
// Pixel-stream bundle produced by vga_timing_gen and consumed by the draw stages.
// rgb_out is present only when VGA_TEST_PATTERN_EN is defined.
interface vga_timing_gen_if;
    logic [10:0] hcount_out;
    logic [10:0] vcount_out;
    logic        hsync_out;
    logic        vsync_out;
    logic        hblnk_out;
    logic        vblnk_out;
    logic        frame_start;
`ifdef VGA_TEST_PATTERN_EN
    logic [11:0] rgb_out;
`endif

    modport master (
        output hcount_out, vcount_out, hsync_out, vsync_out,
               hblnk_out, vblnk_out, frame_start
`ifdef VGA_TEST_PATTERN_EN
        , output rgb_out
`endif
    );

    modport slave (
        input hcount_out, vcount_out, hsync_out, vsync_out,
              hblnk_out, vblnk_out, frame_start
`ifdef VGA_TEST_PATTERN_EN
        , input rgb_out
`endif
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Head-of-pipeline VGA timing source: counters, sync, blanking and frame_start pulse.
// Define VGA_TEST_PATTERN_EN to add the 8-bar colour test pattern on rgb_out.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 1024,
    parameter int unsigned H_FP     = 24,
    parameter int unsigned H_SYNC   = 136,
    parameter int unsigned H_BP     = 160,
    parameter int unsigned V_ACTIVE = 768,
    parameter int unsigned V_FP     = 3,
    parameter int unsigned V_SYNC   = 6,
    parameter int unsigned V_BP     = 29,
    parameter int unsigned SYNC_POL = 0
) (
    input  logic             pclk,
    input  logic             rst,
    vga_timing_gen_if.master vid
);
    localparam int unsigned CW      = 11;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic          SYNC_ON  = (SYNC_POL != 0);

    if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 2048");
    end

    logic [CW-1:0] hcount, vcount;
    logic [CW-1:0] h_nxt, v_nxt;
    logic          wrap_nxt;
    logic          hsync, vsync, hblnk, vblnk, frame_start;
    logic          h_win_nxt, v_win_nxt, hblnk_nxt, vblnk_nxt;

    // Next raster position; every output is decoded from it so it aligns with the counts
    always_comb begin
        h_nxt    = hcount + CW'(1);
        v_nxt    = vcount;
        wrap_nxt = 1'b0;
        if (hcount == H_LAST) begin
            h_nxt = '0;
            if (vcount == V_LAST) begin
                v_nxt    = '0;
                wrap_nxt = 1'b1;
            end else begin
                v_nxt = vcount + CW'(1);
            end
        end
    end

    always_comb begin
        hblnk_nxt = (h_nxt >= H_ACT);
        vblnk_nxt = (v_nxt >= V_ACT);
        h_win_nxt = (h_nxt >= HS_FIRST) && (h_nxt <= HS_LAST);
        v_win_nxt = (v_nxt >= VS_FIRST) && (v_nxt <= VS_LAST);
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            hcount      <= '0;
            vcount      <= '0;
            hblnk       <= 1'b0;
            vblnk       <= 1'b0;
            hsync       <= ~SYNC_ON;
            vsync       <= ~SYNC_ON;
            frame_start <= 1'b0;
        end else begin
            hcount      <= h_nxt;
            vcount      <= v_nxt;
            hblnk       <= hblnk_nxt;
            vblnk       <= vblnk_nxt;
            hsync       <= h_win_nxt ? SYNC_ON : ~SYNC_ON;
            vsync       <= v_win_nxt ? SYNC_ON : ~SYNC_ON;
            frame_start <= wrap_nxt;
        end
    end

    assign vid.hcount_out  = hcount;
    assign vid.vcount_out  = vcount;
    assign vid.hsync_out   = hsync;
    assign vid.vsync_out   = vsync;
    assign vid.hblnk_out   = hblnk;
    assign vid.vblnk_out   = vblnk;
    assign vid.frame_start = frame_start;

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [CW-1:0] BAR_W = CW'(H_ACTIVE / 8);

    if (H_ACTIVE % 8 != 0) begin : g_bad_bar
        $error("vga_timing_gen: H_ACTIVE must be divisible by 8");
    end

    logic [2:0]  bar_nxt;
    logic [11:0] rgb_nxt;
    logic [11:0] rgb;

    // Bars left to right: white, yellow, cyan, green, magenta, red, blue, black
    always_comb begin
        bar_nxt = 3'(h_nxt / BAR_W);
        rgb_nxt = 12'h000;
        if (!hblnk_nxt && !vblnk_nxt) begin
            case (bar_nxt)
                3'd0:    rgb_nxt = 12'hFFF;
                3'd1:    rgb_nxt = 12'hFF0;
                3'd2:    rgb_nxt = 12'h0FF;
                3'd3:    rgb_nxt = 12'h0F0;
                3'd4:    rgb_nxt = 12'hF0F;
                3'd5:    rgb_nxt = 12'hF00;
                3'd6:    rgb_nxt = 12'h00F;
                default: rgb_nxt = 12'h000;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            rgb <= 12'h000;
        end else begin
            rgb <= rgb_nxt;
        end
    end

    assign vid.rgb_out = rgb;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: linear-index raster model checked every cycle plus directed literals.
// Builds with or without VGA_TEST_PATTERN_EN.
module tb_vga_timing_gen;
    localparam int S_HA = 16, S_HF = 2, S_HS = 3, S_HB = 3;
    localparam int S_VA = 8,  S_VF = 1, S_VS = 2, S_VB = 2;
    localparam int TOT0 = 1344 * 806;
    localparam int TOT1 = (S_HA + S_HF + S_HS + S_HB) * (S_VA + S_VF + S_VS + S_VB);

    logic pclk = 1'b0;
    logic rst0 = 1'b1;
    logic rst1 = 1'b1;
    always #5 pclk = ~pclk;

    vga_timing_gen_if vid0();
    vga_timing_gen_if vid1();
    vga_timing_gen_if vid2();

    vga_timing_gen u_dut (.pclk(pclk), .rst(rst0), .vid(vid0));

    vga_timing_gen #(
        .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB), .SYNC_POL(0)
    ) u_small (.pclk(pclk), .rst(rst1), .vid(vid1));

    vga_timing_gen #(
        .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB), .SYNC_POL(1)
    ) u_pol (.pclk(pclk), .rst(rst1), .vid(vid2));

    logic [11:0] rgb0, rgb1, rgb2;
`ifdef VGA_TEST_PATTERN_EN
    assign rgb0 = vid0.rgb_out;
    assign rgb1 = vid1.rgb_out;
    assign rgb2 = vid2.rgb_out;
`else
    assign rgb0 = 12'h000;
    assign rgb1 = 12'h000;
    assign rgb2 = 12'h000;
`endif

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] bar_colour(input int bar);
        case (bar)
            0:       return 12'hFFF;
            1:       return 12'hFF0;
            2:       return 12'h0FF;
            3:       return 12'h0F0;
            4:       return 12'hF0F;
            5:       return 12'hF00;
            6:       return 12'h00F;
            default: return 12'h000;
        endcase
    endfunction

    // Expected {h, v, hsync, vsync, hblnk, vblnk, frame_start, rgb} for a pixel index in the frame
    function automatic logic [38:0] model(input int idx, input int ha, input int hf, input int hs,
                                          input int hb, input int va, input int vf, input int vs,
                                          input int vb, input bit pol, input bit fs);
        int h, v, ht;
        bit hbl, vbl, hw, vw, hsy, vsy;
        logic [11:0] rgb;
        ht  = ha + hf + hs + hb;
        h   = idx % ht;
        v   = idx / ht;
        hbl = (h >= ha);
        vbl = (v >= va);
        hw  = (h >= ha + hf) && (h < ha + hf + hs);
        vw  = (v >= va + vf) && (v < va + vf + vs);
        hsy = pol ? hw : !hw;
        vsy = pol ? vw : !vw;
        rgb = 12'h000;
`ifdef VGA_TEST_PATTERN_EN
        if (!hbl && !vbl) rgb = bar_colour(h * 8 / ha);
`endif
        if (vb < 0) rgb = 12'h000;
        return {11'(h), 11'(v), hsy, vsy, hbl, vbl, fs, rgb};
    endfunction

    // Model: count pixels since reset modulo the frame size; a wrap back to 0 is a frame start
    int idx0 = 0, idx1 = 0;
    bit fs0 = 1'b0, fs1 = 1'b0;
    bit started = 1'b0;
    always @(posedge pclk) begin
        started <= 1'b1;
        if (rst0) begin idx0 <= 0; fs0 <= 1'b0; end
        else if (idx0 == TOT0 - 1) begin idx0 <= 0; fs0 <= 1'b1; end
        else begin idx0 <= idx0 + 1; fs0 <= 1'b0; end
        if (rst1) begin idx1 <= 0; fs1 <= 1'b0; end
        else if (idx1 == TOT1 - 1) begin idx1 <= 0; fs1 <= 1'b1; end
        else begin idx1 <= idx1 + 1; fs1 <= 1'b0; end
    end

    int pulses0 = 0, pulses1 = 0;
    int cyc1 = 0, vs_cnt1 = 0, vb_cnt1 = 0;

    always @(negedge pclk) begin
        if (started) begin
            chk("stream_default",
                {vid0.hcount_out, vid0.vcount_out, vid0.hsync_out, vid0.vsync_out,
                 vid0.hblnk_out, vid0.vblnk_out, vid0.frame_start, rgb0},
                model(idx0, 1024, 24, 136, 160, 768, 3, 6, 29, 1'b0, fs0));
            chk("stream_small",
                {vid1.hcount_out, vid1.vcount_out, vid1.hsync_out, vid1.vsync_out,
                 vid1.hblnk_out, vid1.vblnk_out, vid1.frame_start, rgb1},
                model(idx1, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, 1'b0, fs1));
            chk("stream_pol1",
                {vid2.hcount_out, vid2.vcount_out, vid2.hsync_out, vid2.vsync_out,
                 vid2.hblnk_out, vid2.vblnk_out, vid2.frame_start, rgb2},
                model(idx1, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, 1'b1, fs1));
            if (vid0.frame_start === 1'b1) pulses0++;
            if (vid1.frame_start === 1'b1) begin
                if (pulses1 > 0) begin
                    chk("small_frame_period", 64'(cyc1), 64'd312);
                    chk("small_vsync_cycles", 64'(vs_cnt1), 64'd48);
                    chk("small_vblnk_cycles", 64'(vb_cnt1), 64'd120);
                end
                pulses1++;
                cyc1 = 0; vs_cnt1 = 0; vb_cnt1 = 0;
            end
            cyc1++;
            if (vid1.vsync_out === 1'b0) vs_cnt1++;
            if (vid1.vblnk_out === 1'b1) vb_cnt1++;
        end
    end

    task automatic wait_pos(input int h, input int v);
        int n;
        n = 0;
        while (!(vid0.hcount_out == 11'(h) && vid0.vcount_out == 11'(v)) && n < 20000) begin
            @(negedge pclk);
            n++;
        end
        if (n >= 20000) begin
            checks++;
            errors++;
            $display("FAIL wait_pos: position (%0d,%0d) not reached, at (%0d,%0d)",
                     h, v, vid0.hcount_out, vid0.vcount_out);
        end
    endtask

    initial begin
        int low_cnt, first_low, last_low;
        repeat (3) @(negedge pclk);
        chk("rst_hcount", 64'(vid0.hcount_out), 64'd0);
        chk("rst_hsync_pol0", 64'(vid0.hsync_out), 64'd1);
        chk("rst_hsync_pol1", 64'(vid2.hsync_out), 64'd0);
        chk("rst_vsync_pol1", 64'(vid2.vsync_out), 64'd0);
        rst0 = 1'b0;
        rst1 = 1'b0;

        @(negedge pclk);
        chk("first_hcount", 64'(vid0.hcount_out), 64'd1);
        chk("first_vcount", 64'(vid0.vcount_out), 64'd0);
        chk("first_syncs", {62'd0, vid0.hsync_out, vid0.vsync_out}, 64'd3);
        chk("first_blanks", {62'd0, vid0.hblnk_out, vid0.vblnk_out}, 64'd0);
        chk("first_frame_start", 64'(vid0.frame_start), 64'd0);

        wait_pos(1023, 0);
        chk("hblnk_at_1023", 64'(vid0.hblnk_out), 64'd0);
        @(negedge pclk);
        chk("hblnk_at_1024", 64'(vid0.hblnk_out), 64'd1);
        low_cnt = 0; first_low = -1; last_low = -1;
        while (vid0.hcount_out != 11'd1343) begin
            if (vid0.hsync_out == 1'b0) begin
                low_cnt++;
                if (first_low < 0) first_low = int'(vid0.hcount_out);
                last_low = int'(vid0.hcount_out);
            end
            @(negedge pclk);
        end
        chk("hsync_low_cycles", 64'(low_cnt), 64'd136);
        chk("hsync_first_low", 64'(first_low), 64'd1048);
        chk("hsync_last_low", 64'(last_low), 64'd1183);
        @(negedge pclk);
        chk("wrap_hcount", 64'(vid0.hcount_out), 64'd0);
        chk("wrap_vcount", 64'(vid0.vcount_out), 64'd1);

`ifdef VGA_TEST_PATTERN_EN
        wait_pos(0, 10);    chk("rgb_10_0", 64'(rgb0), 64'hFFF);
        wait_pos(127, 10);  chk("rgb_10_127", 64'(rgb0), 64'hFFF);
        wait_pos(128, 10);  chk("rgb_10_128", 64'(rgb0), 64'hFF0);
        wait_pos(1023, 10); chk("rgb_10_1023", 64'(rgb0), 64'h000);
        wait_pos(1024, 10); chk("rgb_10_1024", 64'(rgb0), 64'h000);
        while (!(vid1.vcount_out == 11'd9 && vid1.hcount_out == 11'd3)) @(negedge pclk);
        chk("rgb_small_vblnk", 64'(rgb1), 64'h000);
`endif

        wait_pos(500, 11);
        rst0 = 1'b1;
        @(negedge pclk);
        chk("midrst_pos", {42'd0, vid0.hcount_out, vid0.vcount_out}, 64'd0);
        chk("midrst_syncs", {62'd0, vid0.hsync_out, vid0.vsync_out}, 64'd3);
        chk("midrst_frame_start", 64'(vid0.frame_start), 64'd0);
        rst0 = 1'b0;
        @(negedge pclk);
        chk("midrst_restart_h", 64'(vid0.hcount_out), 64'd1);
        chk("midrst_restart_v", 64'(vid0.vcount_out), 64'd0);

        repeat (2000) @(negedge pclk);
        chk("default_no_pulse", 64'(pulses0), 64'd0);
        chk("small_pulses_seen", 64'(pulses1 >= 40), 64'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Source end of the pixel-stream interface. Generates the registered hcount/vcount, hsync/vsync and hblnk/vblnk stream that every downstream draw stage consumes, including the rectangle/paddle overlay and the background stages.
- Default timing: 1024x768 @ 60 Hz on a 65 MHz pclk.
- Sits at the head of the video pipeline. Also emits a one-cycle frame_start pulse that game logic uses to update paddle and ball positions.

Parameters:
H_ACTIVE, 1024, visible pixels per line
H_FP, 24, horizontal front porch (pixels)
H_SYNC, 136, horizontal sync width (pixels)
H_BP, 160, horizontal back porch (pixels)
V_ACTIVE, 768, visible lines per frame
V_FP, 3, vertical front porch (lines)
V_SYNC, 6, vertical sync width (lines)
V_BP, 29, vertical back porch (lines)
SYNC_POL, 0, sync active level (0 = active-low, 1 = active-high)

Ports:
pclk  in  1  pixel clock
rst  in  1  reset, synchronous, active-high
hcount_out  out  11  horizontal pixel counter
vcount_out  out  11  vertical line counter
hsync_out  out  1  horizontal sync, polarity set by SYNC_POL
vsync_out  out  1  vertical sync, polarity set by SYNC_POL
hblnk_out  out  1  high outside the visible columns
vblnk_out  out  1  high outside the visible lines
frame_start  out  1  one-cycle pulse at the start of each frame
rgb_out  out  12  test-pattern colour (present only with VGA_TEST_PATTERN_EN)

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1344); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (806). Both totals must be ≤ 2048.
- Reset values:
  - hcount_out = 0, vcount_out = 0
  - hblnk_out = 0, vblnk_out = 0
  - hsync_out = vsync_out = inactive level (~SYNC_POL)
  - frame_start = 0, rgb_out = 0
- Counting, every pclk edge with rst low:
  - hcount increments by 1.
  - At hcount = H_TOTAL-1 it wraps to 0 and vcount increments.
  - At hcount = H_TOTAL-1 and vcount = V_TOTAL-1 both wrap to 0.
- All outputs are registered and mutually aligned: each cycle's sync/blank/frame_start/rgb describe the same (hcount_out, vcount_out) shown that cycle. This is zero additional latency relative to the counters. Decode the next-count value, then register it together with the counter.
- hblnk_out = 1 iff hcount ≥ H_ACTIVE. vblnk_out = 1 iff vcount ≥ V_ACTIVE.
- hsync active iff H_ACTIVE+H_FP ≤ hcount < H_ACTIVE+H_FP+H_SYNC, i.e. [1048, 1184).
- vsync active iff V_ACTIVE+V_FP ≤ vcount < V_ACTIVE+V_FP+V_SYNC, i.e. [771, 777). vsync is evaluated on vcount only and changes at hcount = 0.
- frame_start:
  - High exactly in the cycle where the outputs show (0,0) reached by wrap from (H_TOTAL-1, V_TOTAL-1).
  - Not asserted for the reset-state (0,0).
- Reset mid-frame: on the next edge, outputs return to reset values. The count restarts at (1,0) on the first edge after rst deasserts, with no frame_start until the next full wrap.
- Period: frame_start period = H_TOTAL*V_TOTAL = 1,083,264 cycles.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined: rgb_out port exists and shows 8 vertical colour bars.
  - Bar index = floor(hcount*8/H_ACTIVE); H_ACTIVE must be divisible by 8, giving 128-pixel bars at default.
  - Colours in order: FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
  - rgb_out = 000 whenever hblnk or vblnk is active.
  - rgb_out is registered and aligned with the counts.
- Undefined: rgb_out port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then release → first cycle hcount_out = 1, vcount_out = 0, hsync/vsync inactive (1 at SYNC_POL = 0), blanks 0, frame_start = 0.
- Run one line → hblnk rises at hcount 1024; hsync low for hcount 1048..1183 (exactly 136 cycles); hcount wraps 1343 → 0 with vcount 0 → 1.
- Run a full frame → vblnk high for vcount 768..805; vsync low for vcount 771..776 (6 × 1344 cycles); frame_start high once, at (0,0), with exactly 1,083,264 cycles between consecutive pulses.
- Assert rst for 1 cycle at (500, 400) → next outputs (0,0) with reset values; then (1,0); no spurious frame_start.
- SYNC_POL = 1 instance → hsync/vsync high only within the same windows; reset value 0.
- With VGA_TEST_PATTERN_EN: check rgb at (vcount, hcount)
  - (10, 0) = FFF
  - (10, 127) = FFF
  - (10, 128) = FF0
  - (10, 1023) = 000
  - (10, 1024) = 000 (blanked)
  - (770, 300) = 000 (vblnk)
